// File: rtl/codec_i2c_pkg.sv
// Shared types and constants for the WM8731-style I2C register responder.
// Holds the FSM state type, register-file geometry and power-on register values.
package codec_i2c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAckA,
    StByte1,
    StAck1,
    StByte2,
    StAck2,
    StIgnore
  } i2c_state_e;

  localparam int unsigned NUM_REGS         = 11;
  localparam logic [6:0]  LAST_REG         = 7'(NUM_REGS - 1);
  localparam logic [6:0]  RESET_REG        = 7'h0F;
  localparam logic [6:0]  DEFAULT_DEV_ADDR = 7'h1A;

  localparam logic [8:0] CODEC_REG_DEFAULTS [0:NUM_REGS-1] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008,
    9'h09F, 9'h00A, 9'h000, 9'h000, 9'h000
  };

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus stability filter for one I2C line.
// Emits the accepted level and one-cycle rise/fall pulses aligned with level changes.
module i2c_line_filter #(
  parameter int unsigned FilterLen = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (FilterLen < 2) ? 1 : $clog2(FilterLen);

  logic [1:0]      sync_q;
  logic            level_q;
  logic            rise_q;
  logic            fall_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      // A new level is accepted only after FilterLen consecutive differing samples.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FilterLen - 1)) begin
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C write-only target mimicking the WM8731 control port: decodes 3-byte write
// frames, ACKs them and keeps a readable copy of the 9-bit configuration registers.
module i2c_codec_responder
  import codec_i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = DEFAULT_DEV_ADDR,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       I2C_SCLK,
  input  logic       I2C_SDAT_IN,
  output logic       I2C_SDAT_OE,
  input  logic [3:0] RD_ADDR,
  output logic [8:0] RD_DATA,
  output logic       WR_STB,
  output logic [6:0] WR_ADDR,
  output logic [8:0] WR_DATA,
  output logic       BUSY,
  output logic       ERR
);

  localparam logic [3:0] LAST_RD = 4'(NUM_REGS - 1);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_line_filter #(.FilterLen(FILTER_LEN)) u_scl_filter (
    .clk_i  (CLOCK),
    .rst_i  (RESET),
    .line_i (I2C_SCLK),
    .level_o(scl_level),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FilterLen(FILTER_LEN)) u_sda_filter (
    .clk_i  (CLOCK),
    .rst_i  (RESET),
    .line_i (I2C_SDAT_IN),
    .level_o(sda_level),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e state_q, state_d;
  logic       oe_q, oe_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [8:0] data_q, data_d;
  logic       commit_q, commit_d;
  logic       busy_q, busy_d;

  logic       start_evt, stop_evt, last_bit;
  logic [7:0] byte_in;

  // An SDA edge coinciding with an SCL edge is a data change, not a bus condition.
  assign start_evt = sda_fall & scl_level & ~scl_rise & ~scl_fall;
  assign stop_evt  = sda_rise & scl_level & ~scl_rise & ~scl_fall;
  assign last_bit  = scl_rise & (bit_cnt_q == 3'd7);
  assign byte_in   = {shift_q[6:0], sda_level};

  always_comb begin
    state_d    = state_q;
    oe_d       = oe_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    data_d     = data_q;
    commit_d   = 1'b0;
    busy_d     = busy_q;

    if (start_evt) begin
      state_d   = StAddr;
      oe_d      = 1'b0;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b1;
    end else if (stop_evt) begin
      state_d   = StIdle;
      oe_d      = 1'b0;
      bit_cnt_d = 3'd0;
      busy_d    = 1'b0;
    end else begin
      if (scl_rise && (state_q inside {StAddr, StByte1, StByte2})) begin
        shift_d   = byte_in;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      case (state_q)
        StAddr: begin
          if (last_bit) begin
            if (byte_in == {DEV_ADDR, 1'b0}) begin
              state_d = StAckA;
            end else begin
              state_d = StIgnore;
              busy_d  = 1'b0;
            end
          end
        end
        StByte1: begin
          if (last_bit) begin
            state_d    = StAck1;
            reg_addr_d = byte_in[7:1];
            data_d[8]  = byte_in[0];
          end
        end
        StByte2: begin
          if (last_bit) begin
            state_d     = StAck2;
            data_d[7:0] = byte_in;
            commit_d    = 1'b1;
          end
        end
        StAckA, StAck1, StAck2: begin
          // First SCL fall drives the ACK bit, the second one ends it.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d = 1'b0;
              case (state_q)
                StAckA:  state_d = StByte1;
                StAck1:  state_d = StByte2;
                default: state_d = StIgnore;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= StIdle;
      oe_q       <= 1'b0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      reg_addr_q <= 7'h00;
      data_q     <= 9'h000;
      commit_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      oe_q       <= oe_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      data_q     <= data_d;
      commit_q   <= commit_d;
      busy_q     <= busy_d;
    end
  end

  logic [8:0] regs_q [NUM_REGS];
  logic       wr_stb_q;
  logic [6:0] wr_addr_q;
  logic [8:0] wr_data_q;
  logic       err_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      regs_q    <= CODEC_REG_DEFAULTS;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 7'h00;
      wr_data_q <= 9'h000;
      err_q     <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      if (commit_q) begin
        if (reg_addr_q <= LAST_REG) begin
          regs_q[reg_addr_q[3:0]] <= data_q;
          wr_stb_q  <= 1'b1;
          wr_addr_q <= reg_addr_q;
          wr_data_q <= data_q;
        end else if (reg_addr_q == RESET_REG) begin
          regs_q    <= CODEC_REG_DEFAULTS;
          wr_stb_q  <= 1'b1;
          wr_addr_q <= reg_addr_q;
          wr_data_q <= data_q;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // A START seen mid-ACK lets go of SDA immediately rather than a cycle later.
  assign I2C_SDAT_OE = oe_q & ~start_evt;
  assign RD_DATA     = (RD_ADDR <= LAST_RD) ? regs_q[RD_ADDR] : 9'h000;
  assign WR_STB      = wr_stb_q;
  assign WR_ADDR     = wr_addr_q;
  assign WR_DATA     = wr_data_q;
  assign BUSY        = busy_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Directed bench for i2c_codec_responder: bit-banged I2C initiator with an
// open-drain SDA model and hand-computed expectations.
module tb_i2c_codec_responder;

  localparam int H = 12;  // SCL half period in clock cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_line;
  logic       oe;
  logic [3:0] rd_addr = 4'd0;
  logic [8:0] rd_data;
  logic       wr_stb;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       err;

  int   checks = 0;
  int   errors = 0;
  int   stb_cnt = 0;
  int   stb_double = 0;
  logic stb_prev = 1'b0;
  logic oe_seen = 1'b0;
  logic ack;

  assign sda_line = sda_drv & ~oe;

  always #5 clk = ~clk;

  i2c_codec_responder dut (
    .CLOCK      (clk),
    .RESET      (rst),
    .I2C_SCLK   (scl),
    .I2C_SDAT_IN(sda_line),
    .I2C_SDAT_OE(oe),
    .RD_ADDR    (rd_addr),
    .RD_DATA    (rd_data),
    .WR_STB     (wr_stb),
    .WR_ADDR    (wr_addr),
    .WR_DATA    (wr_data),
    .BUSY       (busy),
    .ERR        (err)
  );

  always @(negedge clk) begin
    if (wr_stb) stb_cnt++;
    if (wr_stb && stb_prev) stb_double++;
    stb_prev = wr_stb;
    if (oe) oe_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [8:0] exp);
    rd_addr = a;
    #1;
    check_eq(tag, {23'd0, rd_data}, {23'd0, exp});
  endtask

  task automatic clear_mon();
    stb_cnt = 0;
    oe_seen = 1'b0;
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; cyc(H);
    scl = 1'b1;     cyc(H);
    sda_drv = 1'b0; cyc(H);
    scl = 1'b0;     cyc(3);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; cyc(H - 3);
    scl = 1'b1;     cyc(H);
    sda_drv = 1'b1; cyc(H);
  endtask

  // Sends the top n bits of b; glitch_bit selects a bit whose low phase gets a short SCL pulse.
  task automatic send_bits(input logic [7:0] b, input int n, input int glitch_bit);
    for (int i = 7; i > 7 - n; i--) begin
      sda_drv = b[i];
      if (i == glitch_bit) begin
        cyc(3); scl = 1'b1; cyc(2); scl = 1'b0; cyc(H - 8);
      end else begin
        cyc(H - 3);
      end
      scl = 1'b1; cyc(H);
      scl = 1'b0; cyc(3);
    end
  endtask

  task automatic send_ack(output logic a);
    sda_drv = 1'b1; cyc(H - 3);
    scl = 1'b1;     cyc(H / 2);
    a = ~sda_line;  cyc(H - H / 2);
    scl = 1'b0;     cyc(3);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic a);
    send_bits(b, 8, glitch_bit);
    send_ack(a);
  endtask

  initial begin
    #400us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(4);
    check_eq("rst_oe", {31'd0, oe}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    cyc(4);
    check_eq("reset_oe", {31'd0, oe}, 0);
    check_eq("reset_stb", {31'd0, wr_stb}, 0);
    check_eq("reset_wr_addr", {25'd0, wr_addr}, 0);
    check_eq("reset_wr_data", {23'd0, wr_data}, 0);
    check_eq("reset_busy", {31'd0, busy}, 0);
    check_eq("reset_err", {31'd0, err}, 0);
    check_reg("reset_reg0", 4'd0, 9'h097);
    check_reg("reset_reg6", 4'd6, 9'h09F);
    check_reg("rd_out_of_range11", 4'd11, 9'h000);
    check_reg("rd_out_of_range15", 4'd15, 9'h000);

    // Write reg 2 = 0x012.
    clear_mon();
    i2c_start();
    check_eq("a_busy_after_start", {31'd0, busy}, 1);
    send_byte(8'h34, -1, ack); check_eq("a_ack_addr", {31'd0, ack}, 1);
    send_byte(8'h04, -1, ack); check_eq("a_ack_b1", {31'd0, ack}, 1);
    send_byte(8'h12, -1, ack); check_eq("a_ack_b2", {31'd0, ack}, 1);
    i2c_stop();
    check_eq("a_stb_count", stb_cnt, 1);
    check_eq("a_wr_addr", {25'd0, wr_addr}, 2);
    check_eq("a_wr_data", {23'd0, wr_data}, 32'h012);
    check_reg("a_reg2", 4'd2, 9'h012);
    check_eq("a_busy_after_stop", {31'd0, busy}, 0);

    // Wrong device address.
    clear_mon();
    i2c_start();
    send_byte(8'h36, -1, ack);
    check_eq("b_nack", {31'd0, ack}, 0);
    check_eq("b_busy_drop", {31'd0, busy}, 0);
    send_byte(8'h04, -1, ack);
    check_eq("b_nack_data", {31'd0, ack}, 0);
    i2c_stop();
    check_eq("b_oe_never", {31'd0, oe_seen}, 0);
    check_eq("b_stb_count", stb_cnt, 0);
    check_reg("b_reg2_kept", 4'd2, 9'h012);

    // reg 6 = 0, then the reset register restores all defaults.
    clear_mon();
    i2c_start();
    send_byte(8'h34, -1, ack);
    send_byte(8'h0C, -1, ack);
    send_byte(8'h00, -1, ack);
    i2c_stop();
    check_reg("c_reg6_zero", 4'd6, 9'h000);
    clear_mon();
    i2c_start();
    send_byte(8'h34, -1, ack);
    send_byte(8'h1E, -1, ack);
    send_byte(8'h00, -1, ack); check_eq("c_ack_rstreg", {31'd0, ack}, 1);
    i2c_stop();
    check_reg("c_reg6_default", 4'd6, 9'h09F);
    check_reg("c_reg2_default", 4'd2, 9'h079);
    check_eq("c_stb_count", stb_cnt, 1);
    check_eq("c_wr_addr", {25'd0, wr_addr}, 32'h0F);
    check_eq("c_err", {31'd0, err}, 0);

    // Unimplemented register 12: ACKed, ERR set, trailing byte NACKed.
    clear_mon();
    i2c_start();
    send_byte(8'h34, -1, ack);
    send_byte(8'h18, -1, ack); check_eq("d_ack_b1", {31'd0, ack}, 1);
    send_byte(8'h55, -1, ack); check_eq("d_ack_b2", {31'd0, ack}, 1);
    send_byte(8'hAA, -1, ack); check_eq("d_nack_b3", {31'd0, ack}, 0);
    i2c_stop();
    check_eq("d_stb_count", stb_cnt, 0);
    check_eq("d_err", {31'd0, err}, 1);
    check_eq("d_wr_addr_kept", {25'd0, wr_addr}, 32'h0F);

    // Repeated START after BYTE1 discards the first frame.
    clear_mon();
    i2c_start();
    send_byte(8'h34, -1, ack);
    send_byte(8'h08, -1, ack);
    i2c_start();
    check_eq("e_busy_rs", {31'd0, busy}, 1);
    send_byte(8'h34, -1, ack); check_eq("e_ack_addr2", {31'd0, ack}, 1);
    send_byte(8'h0A, -1, ack);
    send_byte(8'h33, -1, ack);
    i2c_stop();
    check_eq("e_stb_count", stb_cnt, 1);
    check_eq("e_wr_addr", {25'd0, wr_addr}, 5);
    check_reg("e_reg5", 4'd5, 9'h033);
    check_reg("e_reg4_untouched", 4'd4, 9'h00A);

    // RESET while the ACK of BYTE1 is being driven.
    i2c_start();
    send_byte(8'h34, -1, ack);
    send_bits(8'h04, 8, -1);
    sda_drv = 1'b1; cyc(H - 3);
    scl = 1'b1;     cyc(H / 2);
    check_eq("f_oe_in_ack", {31'd0, oe}, 1);
    rst = 1'b1; cyc(1);
    check_eq("f_oe_released", {31'd0, oe}, 0);
    check_eq("f_busy_cleared", {31'd0, busy}, 0);
    check_eq("f_err_cleared", {31'd0, err}, 0);
    rst = 1'b0; cyc(H - H / 2);
    scl = 1'b0; cyc(3);
    i2c_stop();

    // RESET mid-BYTE2: frame is lost.
    clear_mon();
    i2c_start();
    send_byte(8'h34, -1, ack);
    send_byte(8'h04, -1, ack);
    send_bits(8'h77, 4, -1);
    rst = 1'b1; cyc(1);
    check_eq("g_oe_after_rst", {31'd0, oe}, 0);
    rst = 1'b0;
    send_bits(8'h70, 4, -1);
    send_ack(ack);
    check_eq("g_nack_after_rst", {31'd0, ack}, 0);
    i2c_stop();
    check_eq("g_stb_count", stb_cnt, 0);
    check_reg("g_reg2_default", 4'd2, 9'h079);

    // Short SCL glitch during BYTE1 must not shift a bit.
    clear_mon();
    i2c_start();
    send_byte(8'h34, -1, ack);
    send_byte(8'h10, 4, ack); check_eq("h_ack_glitch_byte", {31'd0, ack}, 1);
    send_byte(8'h5A, -1, ack); check_eq("h_ack_b2", {31'd0, ack}, 1);
    i2c_stop();
    check_eq("h_stb_count", stb_cnt, 1);
    check_eq("h_wr_addr", {25'd0, wr_addr}, 8);
    check_eq("h_wr_data", {23'd0, wr_data}, 32'h05A);
    check_reg("h_reg8", 4'd8, 9'h05A);

    check_eq("stb_single_cycle", stb_double, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_codec_responder.md
# i2c_codec_responder

Synthesizable I2C target that models the write-only register port of the WM8731 audio codec: 7-bit device address, 3-byte write frames (address, {reg[6:0], data[8]}, data[7:0]), ACK generation, and a 9-bit register file. It sits on the FPGA side of the I2C bus opposite the codec-configuration initiator. It allows on-board loopback checks of the configuration sequence and lets other logic read back the configuration the codec was sent.

## Interface
- DEV_ADDR, 7'h1A: target address; only write (R/W=0) frames to this address are ACKed.
- FILTER_LEN, 3: clock cycles a synchronized SCL/SDA level must stay stable before it is accepted.
- CLOCK  in  1  system clock, 50 MHz; must be at least 20× the SCL rate.
- RESET  in  1  synchronous, active-high reset.
- I2C_SCLK  in  1  bus clock, sampled asynchronously.
- I2C_SDAT_IN  in  1  bus data level, sampled asynchronously.
- I2C_SDAT_OE  out  1  1 = pull SDA low (open-drain); the top level builds the tristate.
- RD_ADDR  in  4  register-file read index, 0..10.
- RD_DATA  out  9  combinational read of reg[RD_ADDR]; 9'h000 if RD_ADDR>10.
- WR_STB  out  1  one-cycle pulse when a register is written.
- WR_ADDR  out  7  register address of the last accepted write.
- WR_DATA  out  9  data of the last accepted write.
- BUSY  out  1  high from accepted START to STOP.
- ERR  out  1  sticky; set on a write to an unimplemented register. Cleared by RESET only.

## Operation
- Line conditioning: SCL and SDA each pass a 2-flop synchronizer, then a stability filter of FILTER_LEN cycles. The filter produces the clean level plus one-cycle rise/fall pulses.
- START: SDA falls while SCL is high. Entered from any state; it also acts as a repeated START. STOP: SDA rises while SCL is high. From any state it goes to IDLE.
- FSM states: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
- Data bits are shifted MSB-first on the SCL rise. A bit counter of 0..7 wraps after the 8th bit.
- ADDR:
  - After the 8th bit, if {addr, rw} == {DEV_ADDR, 0}, the next state is ACK_A.
  - Otherwise the next state is IGNORE: no ACK, OE stays 0, BUSY drops.
- ACK_x states:
  - OE goes to 1 on the SCL fall that ends bit 8.
  - OE goes back to 0 on the following SCL fall.
  - The FSM then advances to BYTE1, BYTE2, or IGNORE respectively.
- BYTE1 latches reg[6:0] and data[8]. BYTE2 latches data[7:0].
- Commit happens on the SCL rise of BYTE2 bit 8, one cycle after the filtered edge. Outcome by register address:
  - reg ≤ 10: write reg, pulse WR_STB, update WR_ADDR and WR_DATA.
  - reg == 7'h0F (reset register): load all registers with their defaults, pulse WR_STB, update WR_ADDR and WR_DATA.
  - Any other address: no write, no WR_STB, set ERR. The ACK is still given.
- IGNORE: any further bytes are NACKed (OE stays 0); the FSM waits for STOP or START.
- Register defaults come from package constant CODEC_REG_DEFAULTS (reg0 = 9'h097, reg6 = 9'h09F, …).

## Timing
- Reset values: I2C_SDAT_OE=0, WR_STB=0, WR_ADDR=0, WR_DATA=0, BUSY=0, ERR=0, FSM=IDLE, registers = defaults, filters preset to 1.
- A reset asserted mid-frame releases SDA on the same edge; the frame is lost, no WR_STB.
- Input-to-event latency: 2 + FILTER_LEN cycles from a pin transition to the filtered edge pulse. OE changes 1 cycle after the filtered SCL-fall pulse.
- The SCL low period must be at least 2 + FILTER_LEN + 2 cycles.
- WR_STB is exactly 1 cycle wide, at most one per frame.
- Simultaneous filtered edges (SCL and SDA changing in the same cycle) are treated as a data change, not START/STOP.
- START detected during ACK_x: OE is released the same cycle and the FSM goes to ADDR.
- BUSY rises the cycle after START is detected and falls the cycle after STOP or an address mismatch.

## Structure
- Package codec_i2c_pkg: the FSM state enum, NUM_REGS=11, RESET_REG=7'h0F, CODEC_REG_DEFAULTS[0:10], and the default DEV_ADDR.
- Sub-module i2c_line_filter: synchronizer, stability filter and rise/fall pulse generation. Instantiated once for SCL and once for SDA.
- The top module holds the FSM, shift register, bit counter and register file.

## Test plan
- Frame 0x34, 0x04, 0x12 (reg 2, data 9'h012): three ACKs, one WR_STB, WR_ADDR=2, WR_DATA=9'h012, RD_ADDR=2 → 9'h012.
- Frame 0x36 (wrong address): NACK at bit 9, OE never asserted, BUSY drops, no WR_STB, registers unchanged.
- Write reg 6 = 9'h000, then frame 0x34, 0x1E, 0x00 (reset register): reg6 returns to 9'h09F, WR_STB pulses, ERR stays 0.
- Frame 0x34, 0x18, 0x55 (reg 12): ACKed, no WR_STB, ERR=1. A fourth byte is then NACKed.
- Repeated START after BYTE1, followed by a valid frame: the first frame is discarded and the second commits. RESET asserted mid-BYTE2 → OE=0 the next cycle and no write occurs.
- Glitch of FILTER_LEN−1 cycles on SCL during BYTE1: no bit shifted, frame commits the correct data.
